serdes_lane_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares one 2-bit serdes packer input lane (`data_bits`/`data_enable`) among `NREQ` requesters. Each requester streams 2-bit beats with per-bit enables, framed by `req_last`. The winner holds the lane for a whole packet, followed by a fixed idle gap. A stalled requester has its packet aborted after a timeout. The block sits directly upstream of the serdes gap-compressing packer and drives its `data_bits`/`data_enable` inputs every cycle.

---
 rtl/serdes_lane_arbiter_if.sv | 29 ++
 rtl/serdes_lane_arbiter.sv | 151 +++++++++++++++
 tb/tb_serdes_lane_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serdes_lane_arbiter_if.sv
// Requester and packer-lane signal bundle for serdes_lane_arbiter.
// Latency: none; this file only groups the wires.
// Backpressure: req_ready qualifies each requester's beat; the lane toward the packer has no backpressure.
interface serdes_lane_arbiter_if #(
  parameter int NREQ = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [2*NREQ-1:0] req_bits;
  logic [2*NREQ-1:0] req_enable;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [1:0]        data_bits;
  logic [1:0]        data_enable;
  logic              grant_valid;
  logic [IDW-1:0]    grant_id;
  logic              pkt_abort;

  modport master (
    output req_valid, req_bits, req_enable, req_last,
    input  req_ready, data_bits, data_enable, grant_valid, grant_id, pkt_abort
  );

  modport slave (
    input  req_valid, req_bits, req_enable, req_last,
    output req_ready, data_bits, data_enable, grant_valid, grant_id, pkt_abort
  );
endinterface

// File: rtl/serdes_lane_arbiter.sv
// Packet-level round-robin arbiter sharing one 2-bit packer lane among NREQ requesters.
// Latency: grant 1 cycle after valid seen in IDLE; each accepted beat appears on data_* 1 cycle later.
// Backpressure: only the owner sees req_ready (state-derived); a stalled owner is aborted after STALL_LIMIT idle cycles.
module serdes_lane_arbiter #(
  parameter int NREQ        = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int STALL_LIMIT = 15
) (
  input logic               clk,
  input logic               resetn,
  serdes_lane_arbiter_if.slave lane
);
  localparam int IDW = $clog2(NREQ);
  localparam int SCW = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;
  localparam int GCW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [SCW-1:0] STALL_MAX = '1;
  localparam logic [SCW-1:0] STALL_LIM = SCW'(STALL_LIMIT);
  localparam logic [GCW-1:0] GAP_LAST  = GCW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IDW-1:0] ID_MAX    = IDW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [SCW-1:0] stall_q, stall_d;
  logic [GCW-1:0] gap_q, gap_d;
  logic [1:0]     data_bits_q, data_bits_d;
  logic [1:0]     data_enable_q, data_enable_d;
  logic           abort_q, abort_d;

  logic [NREQ-1:0] ready;
  logic [1:0]      own_bits, own_en;
  logic            own_last, own_valid, xfer;
  logic            found;
  logic [IDW-1:0]  winner, scan_idx;
  logic [SCW-1:0]  stall_inc;
  logic            end_pkt;

  // Only the current owner is offered ready, and only while a packet is in progress.
  always_comb begin
    ready = '0;
    if (state_q == XFER) ready[grant_id_q] = 1'b1;
  end

  // Select the owner's slice of the request buses.
  always_comb begin
    own_bits  = lane.req_bits[{grant_id_q, 1'b0} +: 2];
    own_en    = lane.req_enable[{grant_id_q, 1'b0} +: 2];
    own_last  = lane.req_last[grant_id_q];
    own_valid = lane.req_valid[grant_id_q];
    xfer      = (state_q == XFER) && own_valid;
  end

  // Round-robin scan: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = IDW'((int'(rr_ptr_q) + k) % NREQ);
      if (!found && lane.req_valid[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  // Next-state and next-output computation for the packet FSM.
  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    stall_d       = stall_q;
    gap_d         = gap_q;
    data_bits_d   = 2'b00;
    data_enable_d = 2'b00;
    abort_d       = 1'b0;
    end_pkt       = 1'b0;
    stall_inc     = (stall_q == STALL_MAX) ? stall_q : stall_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_id_d = winner;
          rr_ptr_d   = (winner == ID_MAX) ? '0 : winner + 1'b1;
          stall_d    = '0;
          state_d    = XFER;
        end
      end
      XFER: begin
        if (xfer) begin
          data_bits_d   = own_bits & own_en;
          data_enable_d = own_en;
          stall_d       = '0;
          end_pkt       = own_last;
        end else begin
          stall_d = stall_inc;
          // A limit of zero disables the timeout entirely.
          if ((STALL_LIMIT != 0) && (stall_inc == STALL_LIM)) begin
            abort_d = 1'b1;
            end_pkt = 1'b1;
          end
        end
        if (end_pkt) begin
          stall_d = '0;
          gap_d   = '0;
          state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset silently drops any packet in flight.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= IDLE;
      grant_id_q    <= '0;
      rr_ptr_q      <= '0;
      stall_q       <= '0;
      gap_q         <= '0;
      data_bits_q   <= 2'b00;
      data_enable_q <= 2'b00;
      abort_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_id_q    <= grant_id_d;
      rr_ptr_q      <= rr_ptr_d;
      stall_q       <= stall_d;
      gap_q         <= gap_d;
      data_bits_q   <= data_bits_d;
      data_enable_q <= data_enable_d;
      abort_q       <= abort_d;
    end
  end

  assign lane.req_ready   = ready;
  assign lane.data_bits   = data_bits_q;
  assign lane.data_enable = data_enable_q;
  assign lane.grant_valid = (state_q == XFER);
  assign lane.grant_id    = grant_id_q;
  assign lane.pkt_abort   = abort_q;
endmodule

// File: tb/tb_serdes_lane_arbiter.sv
// Scoreboard bench for serdes_lane_arbiter: two instances (gap 1 / stall 3, and gap 0 / no timeout).
// Stimulus pushes expected grant/beat/abort events with cycle spacing; a negedge monitor pops and compares.
// Requesters honour req_ready; every wait is bounded and a timeout is reported as a failure.
module tb_serdes_lane_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic [3:0] valid [2];
  logic [7:0] bits  [2];
  logic [7:0] en    [2];
  logic [3:0] last  [2];

  serdes_lane_arbiter_if #(.NREQ(4)) if0 ();
  serdes_lane_arbiter_if #(.NREQ(4)) if1 ();

  assign if0.req_valid  = valid[0];
  assign if0.req_bits   = bits[0];
  assign if0.req_enable = en[0];
  assign if0.req_last   = last[0];
  assign if1.req_valid  = valid[1];
  assign if1.req_bits   = bits[1];
  assign if1.req_enable = en[1];
  assign if1.req_last   = last[1];

  serdes_lane_arbiter #(.NREQ(4), .GAP_CYCLES(1), .STALL_LIMIT(3)) u_dut0 (
    .clk(clk), .resetn(resetn), .lane(if0));
  serdes_lane_arbiter #(.NREQ(4), .GAP_CYCLES(0), .STALL_LIMIT(0)) u_dut1 (
    .clk(clk), .resetn(resetn), .lane(if1));

  logic [1:0] m_bits [2];
  logic [1:0] m_en   [2];
  logic       m_gv   [2];
  logic [1:0] m_gid  [2];
  logic       m_ab   [2];
  logic [3:0] m_rdy  [2];
  assign m_bits[0] = if0.data_bits;   assign m_bits[1] = if1.data_bits;
  assign m_en[0]   = if0.data_enable; assign m_en[1]   = if1.data_enable;
  assign m_gv[0]   = if0.grant_valid; assign m_gv[1]   = if1.grant_valid;
  assign m_gid[0]  = if0.grant_id;    assign m_gid[1]  = if1.grant_id;
  assign m_ab[0]   = if0.pkt_abort;   assign m_ab[1]   = if1.pkt_abort;
  assign m_rdy[0]  = if0.req_ready;   assign m_rdy[1]  = if1.req_ready;

  // kind: 0 grant (val=id), 1 beat (val={bits,en}), 2 abort; dt = cycles since previous event on that DUT, -1 = any
  typedef struct {int d; int kind; int val; int dt;} ev_t;
  // kind: 0 output snapshot, 1 forced failure (stimulus timeout)
  typedef struct {int d; int kind; logic [9:0] expv; string name;} snap_t;

  ev_t   expq  [$];
  snap_t snapq [$];
  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  int    last_ev [2] = '{0, 0};
  logic  gv_prev [2] = '{1'b0, 1'b0};
  logic  final_req = 1'b0;

  task automatic ev(input int d, input int kind, input int val);
    ev_t e;
    int  dt;
    dt = cyc - last_ev[d];
    last_ev[d] = cyc;
    checks++;
    if (expq.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event dut%0d: got kind=%0d val=%0d at cycle %0d, expected no event", d, kind, val, cyc);
    end else begin
      e = expq.pop_front();
      if (e.d != d || e.kind != kind || e.val != val || (e.dt >= 0 && e.dt != dt)) begin
        failures++;
        $display("FAIL event dut%0d: got kind=%0d val=%0d dt=%0d, expected dut%0d kind=%0d val=%0d dt=%0d",
                 d, kind, val, dt, e.d, e.kind, e.val, e.dt);
      end
    end
  endtask

  // Monitor: sole owner of the counters; compares snapshots and output events away from the rising edge.
  always @(negedge clk) begin
    snap_t    s;
    ev_t      e;
    logic [9:0] obs;
    cyc++;
    while (snapq.size() > 0) begin
      s = snapq.pop_front();
      checks++;
      if (s.kind == 1) begin
        failures++;
        $display("FAIL %s dut%0d: handshake never completed, expected acceptance", s.name, s.d);
      end else begin
        obs = {m_bits[s.d], m_en[s.d], m_gv[s.d], m_ab[s.d], m_rdy[s.d]};
        if (obs !== s.expv) begin
          failures++;
          $display("FAIL %s dut%0d: got bits/en/gv/abort/ready=%b, expected %b", s.name, s.d, obs, s.expv);
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      if (m_gv[d] === 1'b1 && gv_prev[d] !== 1'b1) ev(d, 0, int'(m_gid[d]));
      if (m_en[d] !== 2'b00 && m_en[d] !== 2'bxx) ev(d, 1, int'({m_bits[d], m_en[d]}));
      if (m_ab[d] === 1'b1) ev(d, 2, 0);
      gv_prev[d] = m_gv[d];
    end
    if (final_req) begin
      while (expq.size() > 0) begin
        e = expq.pop_front();
        checks++;
        failures++;
        $display("FAIL missing_event dut%0d: got nothing, expected kind=%0d val=%0d", e.d, e.kind, e.val);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_ev(input int d, input int kind, input int val, input int dt);
    ev_t e;
    e.d = d; e.kind = kind; e.val = val; e.dt = dt;
    expq.push_back(e);
  endtask

  task automatic exp_g(input int d, input int id, input int dt);
    exp_ev(d, 0, id, dt);
  endtask

  task automatic exp_b(input int d, input int dbits, input int den, input int dt);
    exp_ev(d, 1, dbits * 4 + den, dt);
  endtask

  task automatic snap(input int d, input int kind, input logic [9:0] expv, input string name);
    snap_t s;
    s.d = d; s.kind = kind; s.expv = expv; s.name = name;
    snapq.push_back(s);
  endtask

  // Present one beat on requester i and hold it until a cycle with req_ready seen.
  task automatic send(input int d, input int i, input logic [1:0] b, input logic [1:0] e, input logic l);
    logic acc;
    int   n;
    valid[d][i]       = 1'b1;
    bits[d][2*i +: 2] = b;
    en[d][2*i +: 2]   = e;
    last[d][i]        = l;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = m_rdy[d][i];
      @(posedge clk);
      #1;
      n++;
    end
    valid[d][i] = 1'b0;
    last[d][i]  = 1'b0;
    if (!acc) snap(d, 1, '0, "send_timeout");
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 200 && expq.size() > 0; n++) tick();
    repeat (3) tick();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
  endtask

  initial begin
    resetn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      valid[d] = '0; bits[d] = '0; en[d] = '0; last[d] = '0;
    end
    tick();
    tick();
    snap(0, 0, 10'b0, "reset_state");
    snap(1, 0, 10'b0, "reset_state");
    tick();
    resetn = 1'b1;
    tick();

    // Single 3-beat packet from requester 2, then gap and idle.
    exp_g(0, 2, -1);
    exp_b(0, 3, 3, 1);
    exp_b(0, 1, 1, 1);
    exp_b(0, 2, 3, 1);
    send(0, 2, 2'd3, 2'd3, 1'b0);
    send(0, 2, 2'd1, 2'd1, 1'b0);
    send(0, 2, 2'd2, 2'd3, 1'b1);
    snap(0, 0, {2'b10, 2'b11, 1'b0, 1'b0, 4'b0000}, "last_beat_in_gap");
    tick();
    snap(0, 0, 10'b0, "idle_after_gap");
    wait_drain();
    do_reset();

    // Round robin: all four hold 1-beat packets, requester 0 queues a second one.
    exp_g(0, 0, -1); exp_b(0, 0, 3, 1);
    exp_g(0, 1, 2);  exp_b(0, 1, 3, 1);
    exp_g(0, 2, 2);  exp_b(0, 2, 3, 1);
    exp_g(0, 3, 2);  exp_b(0, 3, 3, 1);
    exp_g(0, 0, 2);  exp_b(0, 2, 2, 1);
    fork
      begin
        send(0, 0, 2'd0, 2'd3, 1'b1);
        send(0, 0, 2'd3, 2'd2, 1'b1);
      end
      send(0, 1, 2'd1, 2'd3, 1'b1);
      send(0, 2, 2'd2, 2'd3, 1'b1);
      send(0, 3, 2'd3, 2'd3, 1'b1);
    join
    wait_drain();
    do_reset();

    // Masking, and a zero-enable last beat that still closes the packet.
    exp_g(0, 0, -1); exp_b(0, 1, 1, 1);
    exp_g(0, 1, 3);  exp_b(0, 2, 2, 1);
    fork
      begin
        send(0, 0, 2'd3, 2'b01, 1'b0);
        send(0, 0, 2'd3, 2'b00, 1'b1);
      end
      send(0, 1, 2'd2, 2'd2, 1'b1);
    join
    wait_drain();
    do_reset();

    // Stall abort: owner 1 goes silent after one beat; requester 0 waits.
    exp_g(0, 1, -1); exp_b(0, 1, 3, 1);
    exp_ev(0, 2, 0, 3);
    exp_g(0, 0, 2);  exp_b(0, 2, 3, 1);
    fork
      send(0, 1, 2'd1, 2'd3, 1'b0);
      begin
        tick();
        tick();
        send(0, 0, 2'd2, 2'd3, 1'b1);
      end
    join
    wait_drain();
    do_reset();

    // Reset during owner 3's second beat; afterwards requester 0 wins over 3.
    exp_g(0, 3, -1); exp_b(0, 3, 3, 1);
    exp_g(0, 0, 2);  exp_b(0, 1, 3, 1);
    valid[0][3] = 1'b1; bits[0][7:6] = 2'd3; en[0][7:6] = 2'd3; last[0][3] = 1'b0;
    tick();
    tick();
    bits[0][7:6] = 2'd2;
    resetn = 1'b0;
    valid[0][0] = 1'b1; bits[0][1:0] = 2'd1; en[0][1:0] = 2'd3; last[0][0] = 1'b1;
    tick();
    resetn = 1'b1;
    snap(0, 0, 10'b0, "reset_mid_packet");
    tick();
    tick();
    valid[0] = '0;
    last[0]  = '0;
    wait_drain();
    do_reset();

    // No gap: requester 1 alone sends two back-to-back packets.
    exp_g(1, 1, -1); exp_b(1, 1, 3, 1);
    exp_g(1, 1, 1);  exp_b(1, 1, 1, 1);
    send(1, 1, 2'd1, 2'd3, 1'b1);
    send(1, 1, 2'd3, 2'd1, 1'b1);
    wait_drain();
    do_reset();

    // No gap: requester 2 pending is served between requester 1's two packets.
    exp_g(1, 1, -1); exp_b(1, 1, 3, 1);
    exp_g(1, 2, 1);  exp_b(1, 2, 3, 1);
    exp_g(1, 1, 1);  exp_b(1, 1, 1, 1);
    fork
      begin
        send(1, 1, 2'd1, 2'd3, 1'b1);
        send(1, 1, 2'd3, 2'd1, 1'b1);
      end
      send(1, 2, 2'd2, 2'd3, 1'b1);
    join
    wait_drain();

    final_req = 1'b1;
    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
